// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit controller.
package uart_tx_pkg;

    // Frame sequencer states; encodings 6 and 7 are illegal and recover to StIdle.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop1  = 3'd4,
        StStop2  = 3'd5
    } tx_state_e;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Source-side handshake bundle: data word, per-frame config and the Accept strobe.
interface uart_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  DataValid;
    logic [DATA_WIDTH-1:0] PData;
    logic                  ParityEn;
    logic                  ParityType;
    logic                  TwoStop;
    logic                  Accept;

    // Data source drives the word and config, observes Accept.
    modport master (
        output DataValid, PData, ParityEn, ParityType, TwoStop,
        input  Accept
    );

    // Transmitter samples the word and config, drives Accept.
    modport slave (
        input  DataValid, PData, ParityEn, ParityType, TwoStop,
        output Accept
    );
endinterface

// File: rtl/uart_tx_shifter.sv
// Data shift register plus saturating bit counter for one UART frame.
module uart_tx_shifter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    input  logic                  i_count,
    output logic                  o_bit,
    output logic                  o_done
);
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_last;

    assign w_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));
    assign o_bit  = r_shift[0];
    assign o_done = w_last;

    // Shift register: a parallel load always wins over a shift.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
        end
    end

    // Bit counter: cleared on load, saturates on the last data bit so it cannot wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count && !w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame FSM, config latch, parity and registered line outputs.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     TxEn,
    uart_tx_if.slave src,
    output logic     TxOut,
    output logic     Busy
);
    tx_state_e r_state;
    tx_state_e w_state_nxt;

    logic r_par_en;
    logic r_parity;
    logic r_two_stop;
    logic r_txout;
    logic r_busy;
    logic r_rst_dly;

    logic w_accept;
    logic w_last_stop;
    logic w_shift;
    logic w_count;
    logic w_bit;
    logic w_done;
    logic w_txout_nxt;
    logic w_busy_nxt;

    // A new frame may start from idle or on the tick that ends the final stop bit.
    assign w_last_stop = (r_state == StStop2) || ((r_state == StStop1) && !r_two_stop);
    assign w_accept    = ((r_state == StIdle) || w_last_stop) && src.DataValid && TxEn
                         && !RST && !r_rst_dly;
    assign src.Accept  = w_accept;
    assign TxOut       = r_txout;
    assign Busy        = r_busy;

    uart_tx_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_shifter (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_load  (w_accept),
        .i_data  (src.PData),
        .i_shift (w_shift),
        .i_count (w_count),
        .o_bit   (w_bit),
        .o_done  (w_done)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; legal states only move on a baud tick.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) w_state_nxt = StStart;
            end
            StStart: begin
                if (TxEn) w_state_nxt = StData;
            end
            StData: begin
                if (TxEn && w_done) w_state_nxt = r_par_en ? StParity : StStop1;
            end
            StParity: begin
                if (TxEn) w_state_nxt = StStop1;
            end
            StStop1: begin
                if (TxEn) begin
                    if (r_two_stop)    w_state_nxt = StStop2;
                    else if (w_accept) w_state_nxt = StStart;
                    else               w_state_nxt = StIdle;
                end
            end
            StStop2: begin
                if (TxEn) w_state_nxt = w_accept ? StStart : StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Output decode: line level and busy for the state being entered, shifter controls.
    always_comb begin
        w_txout_nxt = IDLE_LEVEL;
        case (w_state_nxt)
            StStart:  w_txout_nxt = 1'b0;
            StData:   w_txout_nxt = w_bit;
            StParity: w_txout_nxt = r_parity;
            default:  w_txout_nxt = IDLE_LEVEL;
        endcase
        w_busy_nxt = (w_state_nxt != StIdle);
        // START also shifts so that shift[0] already holds the next data bit in DATA.
        w_shift    = TxEn && ((r_state == StStart) || (r_state == StData));
        w_count    = TxEn && (r_state == StData);
    end

    // Per-frame config latch, captured together with the data word on Accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_par_en   <= 1'b0;
            r_parity   <= 1'b0;
            r_two_stop <= 1'b0;
        end else if (w_accept) begin
            r_par_en   <= src.ParityEn;
            r_parity   <= (^src.PData) ^ src.ParityType;
            r_two_stop <= src.TwoStop;
        end
    end

    // Line and busy registers; the line only moves on ticks or illegal-state recovery.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_txout <= IDLE_LEVEL;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (TxEn || (w_state_nxt != r_state)) begin
                r_txout <= w_txout_nxt;
            end
        end
    end

    // Remembers a reset in the previous cycle to hold Accept off for one more cycle.
    always_ff @(posedge CLK) begin
        r_rst_dly <= RST;
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus pushes expected frames, monitors check the line.
module tb_uart_tx_ctrl;
    import uart_tx_pkg::*;

    typedef struct {
        logic [12:0] bits;
        int          len;
    } frame_t;

    logic clk = 1'b0;
    logic RST = 1'b1;
    logic TxEn = 1'b0;
    logic TxOut, Busy, tx5, busy5, tx9, busy9;

    int tick_div = 1;
    int n_tests  = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int exp_acc  = 0;

    frame_t exp_q[$];
    int     exp_busy_q[$];

    uart_tx_if #(.DATA_WIDTH(8)) sif ();
    uart_tx_if #(.DATA_WIDTH(5)) if5 ();
    uart_tx_if #(.DATA_WIDTH(9)) if9 ();

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK (clk), .RST (RST), .TxEn (TxEn), .src (sif), .TxOut (TxOut), .Busy (Busy)
    );
    uart_tx_ctrl #(.DATA_WIDTH(5)) dut5 (
        .CLK (clk), .RST (RST), .TxEn (TxEn), .src (if5), .TxOut (tx5), .Busy (busy5)
    );
    uart_tx_ctrl #(.DATA_WIDTH(9)) dut9 (
        .CLK (clk), .RST (RST), .TxEn (TxEn), .src (if9), .TxOut (tx9), .Busy (busy9)
    );

    always #5 clk = ~clk;

    // Baud tick: one-cycle TxEn pulse every tick_div cycles, driven on the falling edge.
    initial begin : tick_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            TxEn = (ph == 0);
            ph = (ph + 1 >= tick_div) ? 0 : ph + 1;
        end
    end

    // Accept pulse counter.
    initial begin : acc_mon
        forever begin
            @(negedge clk);
            #2;
            if (sif.Accept === 1'b1) acc_cnt++;
        end
    end

    // Frame monitor: a low line starts a frame, each bit is checked for every cycle it is held.
    initial begin : frame_mon
        frame_t f;
        forever begin
            @(negedge clk);
            #3;
            if (TxOut === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: TxOut=%b with no frame expected", TxOut);
                end else begin
                    f = exp_q.pop_front();
                    for (int b = 0; b < f.len; b++) begin
                        for (int c = 0; c < tick_div; c++) begin
                            if (!(b == 0 && c == 0)) begin
                                @(negedge clk);
                                #3;
                            end
                            n_tests++;
                            if (TxOut !== f.bits[b] || Busy !== 1'b1) begin
                                n_fail++;
                                $display("FAIL frame_bit %0d cyc %0d: got TxOut=%b Busy=%b, want %b/1",
                                         b, c, TxOut, Busy, f.bits[b]);
                            end
                        end
                    end
                end
            end
        end
    end

    // Busy monitor: length of each high run compared against the expected length.
    initial begin : busy_mon
        int run;
        int want;
        run = 0;
        forever begin
            @(negedge clk);
            #3;
            if (Busy === 1'b1) begin
                run++;
            end else if (run > 0) begin
                n_tests++;
                if (exp_busy_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL busy_run: got %0d cycles, want none", run);
                end else begin
                    want = exp_busy_q.pop_front();
                    if (run != want) begin
                        n_fail++;
                        $display("FAIL busy_run: got %0d cycles, want %0d", run, want);
                    end
                end
                run = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic got, input logic want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    // Presents a word until Accept; pushes the expected frame and returns after the capture edge.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic ts,
                        input logic [12:0] bits, input int len);
        frame_t f;
        bit     got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            sif.DataValid  = 1'b1;
            sif.PData      = d;
            sif.ParityEn   = pe;
            sif.ParityType = pt;
            sif.TwoStop    = ts;
            #1;
            if (sif.Accept === 1'b1) begin
                got    = 1'b1;
                f.bits = bits;
                f.len  = len;
                exp_q.push_back(f);
                exp_acc++;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no Accept, want Accept for %h", d);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        sif.DataValid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 500 && !idle; i++) begin
            @(negedge clk);
            #1;
            if (Busy === 1'b0) idle = 1'b1;
        end
        if (!idle) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got Busy=%b, want 0", Busy);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        logic [12:0] f5, f9;
        bit          got;
        sif.DataValid = 1'b1; sif.PData = 8'hA5;
        sif.ParityEn = 1'b0; sif.ParityType = PAR_EVEN; sif.TwoStop = 1'b0;
        if5.DataValid = 1'b0; if5.PData = '0;
        if5.ParityEn = 1'b0; if5.ParityType = 1'b0; if5.TwoStop = 1'b0;
        if9.DataValid = 1'b0; if9.PData = '0;
        if9.ParityEn = 1'b0; if9.ParityType = 1'b0; if9.TwoStop = 1'b0;

        // Reset: Accept held off in the reset cycle and the one after, line idle.
        @(negedge clk);
        #1;
        check("accept_in_reset", sif.Accept, 1'b0);
        @(negedge clk);
        RST = 1'b0;
        #1;
        check("accept_after_reset", sif.Accept, 1'b0);
        check("txout_reset", TxOut, IDLE_LEVEL);
        check("busy_reset", Busy, 1'b0);

        // 8N1, 8'hA5: line 0,1,0,1,0,0,1,0,1,1.
        exp_busy_q.push_back(10);
        send(8'hA5, 1'b0, PAR_EVEN, 1'b0, 13'b1_1010_0101_0, 10);
        drop_valid();
        wait_idle();

        // 8'h03 with parity: even -> 0, odd -> 1, 11 ticks.
        exp_busy_q.push_back(11);
        send(8'h03, 1'b1, PAR_EVEN, 1'b0, 13'b1_0_0000_0011_0, 11);
        drop_valid();
        wait_idle();
        exp_busy_q.push_back(11);
        send(8'h03, 1'b1, PAR_ODD, 1'b0, 13'b1_1_0000_0011_0, 11);
        drop_valid();
        wait_idle();

        // Two stop bits, tick every 4th cycle: every bit held exactly 4 cycles.
        tick_div = 4;
        exp_busy_q.push_back(44);
        send(8'hC3, 1'b0, PAR_EVEN, 1'b1, 13'b11_1100_0011_0, 11);
        drop_valid();
        wait_idle();
        tick_div = 1;
        repeat (4) @(negedge clk);

        // Back-to-back 8'h55 then 8'hF0: one unbroken 20-cycle busy run.
        exp_busy_q.push_back(20);
        send(8'h55, 1'b0, PAR_EVEN, 1'b0, 13'b1_0101_0101_0, 10);
        send(8'hF0, 1'b0, PAR_EVEN, 1'b0, 13'b1_1111_0000_0, 10);
        drop_valid();
        wait_idle();

        // Inputs changed right after Accept must not disturb the frame in flight.
        exp_busy_q.push_back(10);
        send(8'h3C, 1'b0, PAR_EVEN, 1'b0, 13'b1_0011_1100_0, 10);
        @(negedge clk);
        sif.DataValid = 1'b0; sif.PData = 8'hFF;
        sif.ParityEn = 1'b1; sif.ParityType = PAR_ODD; sif.TwoStop = 1'b1;
        wait_idle();

        // Reset while data bit 3 is on the line; 8'h0A leaves zeros that must never appear.
        exp_busy_q.push_back(5);
        send(8'h0A, 1'b0, PAR_EVEN, 1'b0, 13'b0_0001_0100, 5);
        drop_valid();
        repeat (4) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        #1;
        check("txout_after_midreset", TxOut, IDLE_LEVEL);
        check("busy_after_midreset", Busy, 1'b0);
        repeat (15) @(negedge clk);

        // Width variants: 5-bit 5'h16 and 9-bit 9'h1A5, 1 start + data + 1 stop.
        f5 = 13'({1'b1, 5'h16, 1'b0});
        f9 = 13'({1'b1, 9'h1A5, 1'b0});
        if5.PData = 5'h16;
        if9.PData = 9'h1A5;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if5.DataValid = 1'b1;
            if9.DataValid = 1'b1;
            #1;
            if (if5.Accept === 1'b1 && if9.Accept === 1'b1) got = 1'b1;
        end
        check("width_accept", got, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if5.DataValid = 1'b0;
            if9.DataValid = 1'b0;
            #3;
            check($sformatf("w5_bit%0d", i), tx5, (i < 7) ? f5[i] : 1'b1);
            check($sformatf("w5_busy%0d", i), busy5, (i < 7));
            check($sformatf("w9_bit%0d", i), tx9, (i < 11) ? f9[i] : 1'b1);
            check($sformatf("w9_busy%0d", i), busy9, (i < 11));
        end

        // Drain and final bookkeeping.
        for (int i = 0; i < 500 && (exp_q.size() != 0 || exp_busy_q.size() != 0); i++) begin
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL frames_pending: got %0d unsent, want 0", exp_q.size());
        end
        n_tests++;
        if (exp_busy_q.size() != 0) begin
            n_fail++;
            $display("FAIL busy_pending: got %0d unseen runs, want 0", exp_busy_q.size());
        end
        n_tests++;
        if (acc_cnt != exp_acc) begin
            n_fail++;
            $display("FAIL accept_count: got %0d, want %0d", acc_cnt, exp_acc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
